memory_router: RTL and testbench



---
 rtl/memory_router_pkg.sv | 34 +++
 rtl/memory_router_decode.sv | 33 +++
 rtl/memory_router.sv | 161 ++++++++++++++++
 tb/tb_memory_router.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_router_pkg.sv
// Memory router shared types and the default CPU memory map.
package memory_router_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam int MR_NUM_T  = 4;
    localparam int MR_ADDR_W = 27;
    localparam int MR_DATA_W = 32;

    localparam logic [MR_ADDR_W-1:0] MR_T0_BASE = 27'h0000000;
    localparam logic [MR_ADDR_W-1:0] MR_T1_BASE = 27'h0800000;
    localparam logic [MR_ADDR_W-1:0] MR_T2_BASE = 27'h1000000;
    localparam logic [MR_ADDR_W-1:0] MR_T3_BASE = 27'h1000800;

    localparam logic [MR_ADDR_W-1:0] MR_T0_SIZE = 27'h0800000;
    localparam logic [MR_ADDR_W-1:0] MR_T1_SIZE = 27'h0800000;
    localparam logic [MR_ADDR_W-1:0] MR_T2_SIZE = 27'h0000800;
    localparam logic [MR_ADDR_W-1:0] MR_T3_SIZE = 27'h0000800;

    localparam logic [MR_NUM_T*MR_ADDR_W-1:0] MR_DEF_BASE =
        {MR_T3_BASE, MR_T2_BASE, MR_T1_BASE, MR_T0_BASE};
    localparam logic [MR_NUM_T*MR_ADDR_W-1:0] MR_DEF_SIZE =
        {MR_T3_SIZE, MR_T2_SIZE, MR_T1_SIZE, MR_T0_SIZE};

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_router_decode.sv
// Address decoder: finds the target region holding an address.
module memory_router_decode
    import memory_router_pkg::*;
#(
    parameter int NUM_T  = MR_NUM_T,
    parameter int ADDR_W = MR_ADDR_W,
    parameter logic [NUM_T*ADDR_W-1:0] BASE = MR_DEF_BASE,
    parameter logic [NUM_T*ADDR_W-1:0] SIZE = MR_DEF_SIZE,
    parameter int SW = sel_w(NUM_T)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [SW-1:0]     sel_o,
    output logic [ADDR_W-1:0] off_o
);

    // Scan high to low so the lowest matching index is left standing.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        off_o = '0;
        for (int i = NUM_T - 1; i >= 0; i--) begin
            if ({1'b0, addr_i} >= {1'b0, BASE[i*ADDR_W +: ADDR_W]} &&
                {1'b0, addr_i} < ({1'b0, BASE[i*ADDR_W +: ADDR_W]} +
                                  {1'b0, SIZE[i*ADDR_W +: ADDR_W]})) begin
                hit_o = 1'b1;
                sel_o = SW'(i);
                off_o = addr_i - BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/memory_router.sv
// Routes single CPU word requests to one of NUM_T memory targets.
module memory_router
    import memory_router_pkg::*;
#(
    parameter int NUM_T   = MR_NUM_T,
    parameter int ADDR_W  = MR_ADDR_W,
    parameter int DATA_W  = MR_DATA_W,
    parameter logic [NUM_T*ADDR_W-1:0] BASE = MR_DEF_BASE,
    parameter logic [NUM_T*ADDR_W-1:0] SIZE = MR_DEF_SIZE,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        data,
    input  logic                     we,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_W-1:0]        q,
    output logic [NUM_T-1:0]         t_start,
    output logic [NUM_T-1:0]         t_we,
    output logic [NUM_T*ADDR_W-1:0]  t_addr,
    output logic [NUM_T*DATA_W-1:0]  t_d,
    input  logic [NUM_T-1:0]         t_done,
    input  logic [NUM_T*DATA_W-1:0]  t_q
);

    localparam int SW = sel_w(NUM_T);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              dec_hit;
    logic [SW-1:0]     dec_sel;
    logic [ADDR_W-1:0] dec_off;
    logic              sel_done;
    logic              expire;

    memory_router_decode #(
        .NUM_T  (NUM_T),
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .SIZE   (SIZE),
        .SW     (SW)
    ) u_decode (
        .addr_i (address),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel),
        .off_o  (dec_off)
    );

    assign sel_done = t_done[sel_q];
    assign expire   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    assign busy  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done  = (state_q == S_RESP);
    assign error = (state_q == S_RESP) && err_q;
    assign q     = q_q;

    always_comb begin
        t_start = '0;
        t_we    = '0;
        t_addr  = '0;
        t_d     = '0;
        if (state_q == S_ISSUE) begin
            t_start[sel_q] = 1'b1;
        end
        if (busy) begin
            t_we[sel_q]                    = we_q;
            t_addr[sel_q*ADDR_W +: ADDR_W] = off_q;
            t_d[sel_q*DATA_W +: DATA_W]    = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        off_d   = off_q;
        data_d  = data_q;
        we_d    = we_q;
        err_d   = err_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d  = dec_sel;
                    off_d  = dec_off;
                    data_d = data;
                    we_d   = we;
                    cnt_d  = '0;
                    if (dec_hit) begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        q_d     = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Target completion beats a simultaneous timeout.
                if (sel_done) begin
                    if (!we_q) begin
                        q_d = t_q[sel_q*DATA_W +: DATA_W];
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (expire) begin
                    err_d   = 1'b1;
                    q_d     = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            off_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_memory_router.sv
// Directed bench for memory_router with TIMEOUT=16 and the default map.
module tb_memory_router;

    logic         clk = 1'b0;
    logic         reset;
    logic [26:0]  address;
    logic [31:0]  data;
    logic         we;
    logic         start;
    logic         busy;
    logic         done;
    logic         error;
    logic [31:0]  q;
    logic [3:0]   t_start;
    logic [3:0]   t_we;
    logic [107:0] t_addr;
    logic [127:0] t_d;
    logic [3:0]   t_done;
    logic [127:0] t_q;

    int checks   = 0;
    int failures = 0;
    int ts_cnt   = 0;
    int dn_cnt   = 0;

    memory_router #(
        .NUM_T   (4),
        .ADDR_W  (27),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data    (data),
        .we      (we),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .q       (q),
        .t_start (t_start),
        .t_we    (t_we),
        .t_addr  (t_addr),
        .t_d     (t_d),
        .t_done  (t_done),
        .t_q     (t_q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (t_start != 4'b0) ts_cnt++;
        if (done) dn_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        address = '0;
        data    = '0;
        we      = 1'b0;
        start   = 1'b0;
        t_done  = '0;
        t_q     = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_flags", {busy, done, error}, 3'b000);
        chk("rst_q", q, 32'h0);
        chk("rst_tstart", t_start, 4'b0000);
        chk("rst_taddr", t_addr, 108'h0);

        // Read T0 at 0x10, response one cycle after t_start
        address = 27'h0000010; we = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rd_tstart", t_start, 4'b0001);
        chk("rd_taddr", t_addr, 108'h10);
        chk("rd_twe", t_we, 4'b0000);
        chk("rd_busy", {busy, done}, 2'b10);
        tick();
        chk("rd_tstart_off", t_start, 4'b0000);
        t_done = 4'b0001; t_q = 128'h12345678;
        tick();
        t_done = '0;
        chk("rd_done", {done, busy, error}, 3'b100);
        chk("rd_q", q, 32'h12345678);
        tick();
        chk("rd_idle", {busy, done}, 2'b00);
        chk("rd_qhold", q, 32'h12345678);

        // Write T1 at 0x0800004
        address = 27'h0800004; data = 32'hCAFEBABE; we = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; we = 1'b0;
        chk("wr_tstart", t_start, 4'b0010);
        chk("wr_taddr", t_addr, {27'h0, 27'h0, 27'h4, 27'h0});
        chk("wr_twe", t_we, 4'b0010);
        chk("wr_td", t_d, {32'h0, 32'h0, 32'hCAFEBABE, 32'h0});
        tick();
        t_done = 4'b0010; t_q = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        tick();
        t_done = '0;
        chk("wr_done", {done, error}, 2'b10);
        chk("wr_qkeep", q, 32'h12345678);
        tick();

        // Unmapped address
        address = 27'h2000000; start = 1'b1;
        ts_cnt = 0;
        tick();
        start = 1'b0;
        chk("um_done", {done, busy, error}, 3'b101);
        chk("um_q", q, 32'h0);
        chk("um_tstart", ts_cnt, 0);
        tick();

        // Boundary: last word of T1 hits, first word past T3 misses
        address = 27'h0FFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bd_tstart", t_start, 4'b0010);
        chk("bd_taddr", t_addr, {27'h0, 27'h0, 27'h7FFFFF, 27'h0});
        tick();
        t_done = 4'b0010; t_q = {32'h0, 32'h0, 32'h11112222, 32'h0};
        tick();
        t_done = '0;
        chk("bd_q", {error, q}, {1'b0, 32'h11112222});
        tick();
        address = 27'h1001000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bd_miss", {done, error}, 2'b11);
        tick();

        // Timeout on T2, with a stray t_done from T0 ignored
        address = 27'h1000004; start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_tstart", t_start, 4'b0100);
        tick();
        t_done = 4'b0001; t_q = 128'hFFFF;
        tick();
        t_done = '0;
        chk("to_ignore", {busy, done}, 2'b10);
        for (int k = 0; k < 14; k++) tick();
        chk("to_wait16", {busy, done}, 2'b10);
        tick();
        chk("to_done", {done, error}, 2'b11);
        chk("to_q", q, 32'h0);
        tick();

        // t_done in the expiry cycle wins
        address = 27'h1000008; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 15; k++) tick();
        chk("tc_wait16", {busy, done}, 2'b10);
        t_done = 4'b0100; t_q = {32'h0, 32'hA5A50F0F, 32'h0, 32'h0};
        tick();
        t_done = '0;
        chk("tc_done", {done, error}, 2'b10);
        chk("tc_q", q, 32'hA5A50F0F);
        tick();

        // start held high while busy and in RESP
        ts_cnt = 0; dn_cnt = 0;
        address = 27'h1000810; start = 1'b1;
        tick();
        chk("rp_taddr", t_addr, {27'h10, 27'h0, 27'h0, 27'h0});
        tick();
        t_done = 4'b1000; t_q = {32'h0BADF00D, 96'h0};
        tick();
        t_done = '0;
        chk("rp_done", done, 1'b1);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rp_idle", {busy, done}, 2'b00);
        chk("rp_tstarts", ts_cnt, 1);
        chk("rp_dones", dn_cnt, 1);
        chk("rp_q", q, 32'h0BADF00D);

        // Reset during WAIT drops the request
        dn_cnt = 0;
        address = 27'h0000020; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rw_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_after", {busy, done, error}, 3'b000);
        chk("rw_q", q, 32'h0);
        t_done = 4'b0001; t_q = 128'h77;
        tick();
        t_done = '0;
        tick();
        tick();
        chk("rw_nodone", dn_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
